wb_apb_bridge: RTL

Wishbone-slave to APB-master bridge that turns Caravel management-core Wishbone cycles into APB transfers. The APB side drives the input of the peripheral APB crossbar, which decodes the transfer to UART, SPI, I2C, PWM and the other peripherals. The bridge runs one transfer at a time through a registered SETUP/ACCESS state machine, honours slave wait states, and bounds stalled transfers with a timeout.

---
 rtl/wb_apb_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wb_apb_bridge.sv
// Wishbone-slave to APB-master bridge: one registered SETUP/ACCESS transfer at a time,
// with slave wait states and a bounded timeout that forces completion.
module wb_apb_bridge #(
  parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFF0_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] m_apb_addr,
  output logic        m_apb_sel,
  output logic        m_apb_write,
  output logic        m_apb_ena,
  output logic [31:0] m_apb_wdata,
  input  logic [31:0] m_apb_rdata,
  output logic [3:0]  m_apb_pstb,
  input  logic        m_apb_rready,
  output logic        timeout_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          abort_q, abort_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [SW-1:0] pstb_q, pstb_d;
  logic          psel_q, psel_d;
  logic          pena_q, pena_d;
  logic          timeout_q, timeout_d;
  logic          in_window;

  assign in_window = (wbs_adr_i & ADDR_MASK) == ADDR_BASE;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    abort_d    = abort_q;
    ack_d      = 1'b0;
    rdat_d     = rdat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    pstb_d     = pstb_q;
    psel_d     = psel_q;
    pena_d     = pena_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (in_window) begin
            addr_d     = wbs_adr_i;
            wdata_d    = wbs_dat_i;
            write_d    = wbs_we_i;
            pstb_d     = wbs_we_i ? wbs_sel_i : SW'(0);
            psel_d     = 1'b1;
            pena_d     = 1'b0;
            abort_d    = 1'b0;
            wait_cnt_d = CW'(0);
            state_d    = SETUP;
          end else begin
            // Unmapped address: answer immediately, reads return zero
            if (!wbs_we_i) begin
              rdat_d = DW'(0);
            end
            ack_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        abort_d = abort_q | ~wbs_cyc_i;
        pena_d  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        abort_d = abort_q | ~wbs_cyc_i;
        if (m_apb_rready) begin
          if (!write_q) begin
            rdat_d = m_apb_rdata;
          end
          psel_d  = 1'b0;
          pena_d  = 1'b0;
          ack_d   = ~abort_q & wbs_cyc_i;
          state_d = DONE;
        end else if (wait_cnt_q == TIMEOUT_LIMIT) begin
          if (!write_q) begin
            rdat_d = {DW{1'b1}};
          end
          timeout_d = 1'b1;
          psel_d    = 1'b0;
          pena_d    = 1'b0;
          ack_d     = ~abort_q & wbs_cyc_i;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= CW'(0);
      abort_q    <= 1'b0;
      ack_q      <= 1'b0;
      rdat_q     <= DW'(0);
      addr_q     <= DW'(0);
      wdata_q    <= DW'(0);
      write_q    <= 1'b0;
      pstb_q     <= SW'(0);
      psel_q     <= 1'b0;
      pena_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      abort_q    <= abort_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      pstb_q     <= pstb_d;
      psel_q     <= psel_d;
      pena_q     <= pena_d;
      timeout_q  <= timeout_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdat_q;
  assign m_apb_addr  = addr_q;
  assign m_apb_wdata = wdata_q;
  assign m_apb_write = write_q;
  assign m_apb_pstb  = pstb_q;
  assign m_apb_sel   = psel_q;
  assign m_apb_ena   = pena_q;
  assign timeout_o   = timeout_q;

endmodule
